// File: rtl/sevenseg_to_hex_capture.sv
// Captures a scanned, active-low 4-digit 7-segment bus and decodes it back to a 16-bit hex frame.
// Optional build macro SEG_ALT9_EN: also accept the tailed 9 (abcdefg = 1111011).
module sevenseg_to_hex_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  anode_n,
  input  logic [6:0]  cathode_n,
  output logic [15:0] Out,
  output logic        valid,
  output logic [3:0]  digit_err,
  output logic        frame_err
);

  localparam int unsigned PAIR_W     = 11;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned OUT_W      = NUM_DIGITS * NIB_W;

  localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [0:0] ST_SETTLE   = 1'b0;
  localparam logic [0:0] ST_CAPTURED = 1'b1;

  // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [NIB_W:0] seg_decode(input logic [6:0] seg);
    logic [NIB_W:0] r;
    r = {1'b1, 4'h0};
    case (seg)
      7'b1111110: r = {1'b0, 4'h0};
      7'b0110000: r = {1'b0, 4'h1};
      7'b1101101: r = {1'b0, 4'h2};
      7'b1111001: r = {1'b0, 4'h3};
      7'b0110011: r = {1'b0, 4'h4};
      7'b1011011: r = {1'b0, 4'h5};
      7'b1011111: r = {1'b0, 4'h6};
      7'b1110000: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1110011: r = {1'b0, 4'h9};
`ifdef SEG_ALT9_EN
      7'b1111011: r = {1'b0, 4'h9};
`endif
      7'b1110111: r = {1'b0, 4'hA};
      7'b0011111: r = {1'b0, 4'hB};
      7'b1001110: r = {1'b0, 4'hC};
      7'b0111101: r = {1'b0, 4'hD};
      7'b1001111: r = {1'b0, 4'hE};
      7'b1000111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  logic [PAIR_W-1:0]     sync1_q, sync1_d;
  logic [PAIR_W-1:0]     sync2_q, sync2_d;
  logic [PAIR_W-1:0]     prev_q, prev_d;
  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [NUM_DIGITS-1:0] err_sh_q, err_sh_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  valid_q, valid_d;
  logic [NUM_DIGITS-1:0] digit_err_q, digit_err_d;
  logic                  frame_err_q, frame_err_d;

  logic [3:0]            anode_s;
  logic [6:0]            seg_s;
  logic                  pair_chg;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  capture;
  logic [NUM_DIGITS-1:0] slot_oh;
  logic [NIB_W:0]        dec;

  assign sync1_d  = {anode_n, cathode_n};
  assign sync2_d  = sync1_q;
  assign prev_d   = sync2_q;
  assign anode_s  = sync2_q[PAIR_W-1:7];
  assign seg_s    = ~sync2_q[6:0];
  assign pair_chg = (sync2_q != prev_q);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign dec      = seg_decode(seg_s);

  // Qualification: a pair must hold STABLE_CYCLES synchronized clocks before one capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    capture = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (pair_chg) cnt_d = CNT_ONE;
        if (cnt_d >= STABLE_TGT) begin
          state_d = ST_CAPTURED;
          capture = 1'b1;
        end
      end
      ST_CAPTURED: begin
        if (pair_chg) begin
          cnt_d = CNT_ONE;
          if (cnt_d >= STABLE_TGT) capture = 1'b1;
          else                     state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // Only a single selected anode maps to a slot; blank and multi-select scans map to none.
  always_comb begin
    slot_oh = '0;
    case (anode_s)
      4'b1110: slot_oh = 4'b0001;
      4'b1101: slot_oh = 4'b0010;
      4'b1011: slot_oh = 4'b0100;
      4'b0111: slot_oh = 4'b1000;
      default: slot_oh = '0;
    endcase
  end

  // Shadow capture and frame completion; shadow nibbles persist across frames.
  always_comb begin
    shadow_d    = shadow_q;
    seen_d      = seen_q;
    err_sh_d    = err_sh_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    digit_err_d = digit_err_q;
    frame_err_d = frame_err_q;
    if (capture && (slot_oh != '0)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (slot_oh[i]) begin
          shadow_d[i*NIB_W +: NIB_W] = dec[NIB_W-1:0];
          err_sh_d[i]                = dec[NIB_W];
        end
      end
      seen_d = seen_q | slot_oh;
      if (seen_d == '1) begin
        out_d       = shadow_d;
        digit_err_d = err_sh_d;
        frame_err_d = |err_sh_d;
        valid_d     = 1'b1;
        seen_d      = '0;
        err_sh_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      seen_q      <= '0;
      err_sh_q    <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      digit_err_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      seen_q      <= seen_d;
      err_sh_q    <= err_sh_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      digit_err_q <= digit_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Out       = out_q;
  assign valid     = valid_q;
  assign digit_err = digit_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sevenseg_to_hex_capture.sv
// Scoreboard bench for sevenseg_to_hex_capture: directed scans push expected frames, a monitor checks each valid.
module tb_sevenseg_to_hex_capture;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  derr;
    logic        ferr;
  } exp_t;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1110011, SA = 7'b1110111, SE = 7'b1001111;
  localparam logic [6:0] SF = 7'b1000111, SDASH = 7'b0000001, SALT9 = 7'b1111011, SBLANK = 7'b0000000;
  localparam logic [3:0] AN0 = 4'b1110, AN1 = 4'b1101, AN2 = 4'b1011, AN3 = 4'b0111;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  anode_n;
  logic [6:0]  cathode_n;
  logic [15:0] Out;
  logic        valid;
  logic [3:0]  digit_err;
  logic        frame_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic valid_prev = 1'b0;

  sevenseg_to_hex_capture #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .anode_n   (anode_n),
    .cathode_n (cathode_n),
    .Out       (Out),
    .valid     (valid),
    .digit_err (digit_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    anode_n   = an;
    cathode_n = ~seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] o, input logic [3:0] de, input logic fe);
    exp_t e;
    e.out = o; e.derr = de; e.ferr = fe;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid pops one expected frame; valid must never last two cycles.
  always @(negedge clk) begin
    if (reset_n && valid) begin
      if (valid_prev) check("valid_one_cycle", 32'(valid_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", 32'(Out), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_out", 32'(Out), 32'(e.out));
        check("frame_digit_err", 32'(digit_err), 32'(e.derr));
        check("frame_frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
    valid_prev <= valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    anode_n   = 4'hF;
    cathode_n = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(Out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_errs", 32'({digit_err, frame_err}), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame 1,2,3,4 with exact capture latency on the last digit
    drive(AN0, S1, HOLD);
    drive(AN1, S2, HOLD);
    drive(AN2, S3, HOLD);
    push(16'h4321, 4'b0000, 1'b0);
    drive(AN3, S4, 5);
    check("latency_not_before_edge6", 32'(valid), 32'd0);
    drive(AN3, S4, 1);
    check("latency_valid_at_edge6", 32'(valid), 32'd1);
    drive(AN3, S4, HOLD - 6);

    // Glitch: 8 held 3 clocks after slot 1 captured 2 must not replace it
    drive(AN0, S5, HOLD);
    drive(AN1, S2, HOLD);
    drive(AN1, S8, 3);
    drive(AN1, S2, 3);
    drive(AN2, S7, HOLD);
    push(16'h0725, 4'b0000, 1'b0);
    drive(AN3, S0, HOLD);

    // Blank and multi-select scans interleaved, result equals plain 1,2,3,4
    drive(AN0, S1, HOLD);
    drive(4'b1111, S8, HOLD);
    drive(AN1, S2, HOLD);
    drive(4'b0011, S5, HOLD);
    drive(AN2, S3, HOLD);
    drive(4'b1111, SBLANK, HOLD);
    push(16'h4321, 4'b0000, 1'b0);
    drive(AN3, S4, HOLD);

    // Invalid pattern: F,E,-,A
    drive(AN0, SF, HOLD);
    drive(AN1, SE, HOLD);
    drive(AN2, SDASH, HOLD);
    push(16'hA0EF, 4'b0100, 1'b1);
    drive(AN3, SA, HOLD);

    // Three digits captured, then a one-clock reset discards them
    drive(AN0, S5, HOLD);
    drive(AN1, S5, HOLD);
    drive(AN2, S5, HOLD);
    anode_n   = 4'hF;
    cathode_n = 7'h7F;
    reset_n   = 1'b0;
    #1;
    check("midreset_out", 32'(Out), 32'd0);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_digit_err", 32'(digit_err), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit 3 first: a leftover seen mask would complete a bogus frame here
    drive(AN3, S6, HOLD);
    drive(AN0, S9, HOLD);
    drive(AN1, S8, HOLD);
    push(16'h6789, 4'b0000, 1'b0);
    drive(AN2, S7, HOLD);

    // Tailed nine on every digit
`ifdef SEG_ALT9_EN
    push(16'h9999, 4'b0000, 1'b0);
`else
    push(16'h0000, 4'b1111, 1'b1);
`endif
    drive(AN0, SALT9, HOLD);
    drive(AN1, SALT9, HOLD);
    drive(AN2, SALT9, HOLD);
    drive(AN3, SALT9, HOLD);

    drive(4'hF, SBLANK, 12);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_to_hex_capture.md
# sevenseg_to_hex_capture

Captures a multiplexed, active-low, four-digit 7-segment display bus (anode scan plus shared cathodes) and decodes it back into a 16-bit hex value. It is the inverse of our hex-to-7-segment encoder, using the same segment table and the same `abcdefg` bit order. It sits on the board-test and loopback path: it observes the display drive, qualifies each scanned digit, and reports a complete frame with per-digit error flags.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive clocks a synchronized anode/cathode pair must hold before a digit is captured. Legal range is 1–255.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `anode_n`  in  4  digit select, active-low. `anode_n[i]` low selects digit i. Digit i maps to `Out[4i+3:4i]`.
- `cathode_n`  in  7  segments, active-low. Bit 6 = a … bit 0 = g.
- `Out`  out  16  last complete captured frame.
- `valid`  out  1  one-cycle pulse, coincident with each `Out` update.
- `digit_err`  out  4  per-digit "pattern not in table" flags for the frame in `Out`.
- `frame_err`  out  1  OR of `digit_err`, registered with `Out`.

## Operation
- Input synchronization:
  - Two-flop synchronizer on `{anode_n, cathode_n}`.
  - Synchronizer flops reset to all-ones (blank).
- Decode works on the inverted synchronized cathodes (`seg = ~cathode_n`), active-high `abcdefg`:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern, including `-` (0000001) and blank (0000000), is invalid: nibble 0 with the error bit set.
- Qualification FSM:
  - SETTLE: compare the current synchronized pair with the previous one.
    - Differs: count <= 1.
    - Equal: count increments.
    - When count reaches `STABLE_CYCLES`, go to CAPTURED and perform a capture.
  - CAPTURED: no further capture. Any change in the pair returns to SETTLE with count = 1.
- Capture rules:
  - Performed only if `anode_n` has exactly one zero bit.
  - Blank scans (1111) or multi-select scans are not captured. They still run the FSM.
  - A capture writes the decoded nibble into shadow slot i, sets `seen[i]`, and writes `err_sh[i]`.
  - Re-capturing an already-seen slot before the frame completes overwrites that slot.
- Frame completion: when a capture makes `seen` = 1111, on that same edge:
  - `Out` <= shadow slots merged with the incoming nibble.
  - `digit_err` <= merged errors; `frame_err` <= OR of them.
  - `valid` <= 1.
  - `seen` and `err_sh` clear.
- The shadow slots are not cleared at frame completion. Only their `seen` bits are.

## Timing
- Reset value of every output is 0. Reset also clears the shadow slots, `seen`, `err_sh`, and the counter, and puts the FSM in SETTLE.
- Reset is asynchronous on assertion. Deassertion is synchronized externally.
- Latency: a capture occurs on edge `2 + STABLE_CYCLES` after the input pair changes and then holds steady. That is 6 edges at the default.
- `valid` is high for exactly one cycle per completed frame. `Out`, `digit_err` and `frame_err` hold until the next frame completes.
- Glitch rejection: a pair held fewer than `STABLE_CYCLES` synchronized cycles is never captured.
- Counter width: 8 bits, saturating.
- Reset mid-frame discards partial capture. After reset, the next frame needs all four digits again.

## Configuration
- `SEG_ALT9_EN` defined: 1111011 (the tailed 9) also decodes to 9 with no error. 1110011 still decodes to 9.
- Not defined: 1111011 is invalid (nibble 0, error bit set).

## Test plan
- Basic frame (`STABLE_CYCLES`=4, each digit held 8 clocks): scan digits 0..3 showing 1,2,3,4 as cathode_n = ~0110000, ~1101101, ~1111001, ~0110011.
  - Required: `Out`=16'h4321, `valid` one cycle, `digit_err`=0000, `frame_err`=0.
- Glitch rejection: hold digit 1 at `2` for 8 clocks, then drive `8` for 3 clocks, then `2` again.
  - Required: slot 1 = 2; no capture of 8.
- Invalid pattern: digit 2 shows `-` in a frame of F,E,-,A.
  - Required: `Out`=16'hA0EF, `digit_err`=0100, `frame_err`=1.
- Blank and multi-select: insert scans with `anode_n`=1111 and 0011 between the digits of a frame.
  - Required: ignored; result is identical to the same frame without them.
- Reset mid-operation: after 3 digits are captured, pulse `reset_n` low for 1 clock, then scan a full frame 9,8,7,6.
  - Required: all outputs 0 during reset; after the frame, `Out`=16'h6789 with one `valid`.
- Macro: cathode pattern ~1111011 on all digits.
  - With `SEG_ALT9_EN`: `Out`=16'h9999, `frame_err`=0.
  - Without it: `Out`=0, `digit_err`=1111.
